mem_arbiter: RTL and testbench

//  Shares one single-port word RAM between instruction fetch (PC/fetch side) and data (load/store) requesters.

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one single-port RAM between instruction fetch and data
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        err
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] C_SMAX  = SW'(MAX_DSTREAK);
    localparam logic [TW-1:0] C_TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DRD  = 2'd2,
        DWR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;

    logic ipend, dreq, force_i, active, tmo_hit;

    assign ipend   = iREN & ~halt;
    assign dreq    = dREN | dWEN;
    assign force_i = ipend && (streak_q == C_SMAX);
    assign active  = (state_q != IDLE);
    assign tmo_hit = (tmo_q == C_TLAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            tmo_q    <= '0;
            addr_q   <= '0;
            store_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        store_d  = store_q;
        if (!ipend) streak_d = '0;
        unique case (state_q)
            IDLE: begin
                if (dreq && !force_i) begin
                    state_d = dWEN ? DWR : DRD;
                    addr_d  = daddr;
                    if (dWEN) store_d = dstore;
                    tmo_d   = '0;
                    // force_i is false here, so streak is below the limit when ipend
                    if (ipend) streak_d = streak_q + 1'b1;
                end else if (ipend) begin
                    state_d  = IACC;
                    addr_d   = iaddr;
                    tmo_d    = '0;
                    streak_d = '0;
                end
            end
            default: begin
                if (ram_ready || tmo_hit) state_d = IDLE;
                else                      tmo_d   = tmo_q + 1'b1;
            end
        endcase
    end

    assign ramREN   = (state_q == IACC) || (state_q == DRD);
    assign ramWEN   = (state_q == DWR);
    assign ramaddr  = active ? addr_q : '0;
    assign ramstore = (state_q == DWR) ? store_q : '0;
    assign ihit     = (state_q == IACC) && ram_ready;
    assign dhit     = ((state_q == DRD) || (state_q == DWR)) && ram_ready;
    assign iload    = ihit ? ramload : '0;
    assign dload    = ((state_q == DRD) && ram_ready) ? ramload : '0;
    assign err      = active && !ram_ready && tmo_hit;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed vector bench for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST, halt, iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST), .halt(halt),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, halt, iren, dren, dwen, rdy;
        logic [31:0] iaddr, daddr, dstore, rload;
        logic [132:0] exp;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input int rst, input int hlt, input int iren, input int ia,
                                input int dren, input int dwen, input int da, input int ds,
                                input int rl, input int rdy,
                                input int ren, input int wen, input int ih, input int dh,
                                input int er, input int ea, input int es, input int eil,
                                input int edl);
        vec_t v;
        v.rst = rst[0]; v.halt = hlt[0]; v.iren = iren[0]; v.dren = dren[0];
        v.dwen = dwen[0]; v.rdy = rdy[0];
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.rload = rl;
        v.exp = {ren[0], wen[0], ih[0], dh[0], er[0], ea, es, eil, edl};
        return v;
    endfunction

    function automatic logic [132:0] outs();
        return {ramREN, ramWEN, ihit, dhit, err, ramaddr, ramstore, iload, dload};
    endfunction

    task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        RST = 1'b0; halt = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        ram_ready = 1'b0; iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
    endtask

    initial begin
        string seq;
        int    ni, nd, ren_cnt, err_at, dh_cnt;
        bit    done;

        // reset, single fetch, write/fetch collision, reset mid-read
        vecs[0]  = mk(1,0,1,0,     1,0,0,0,0,0,            0,0,0,0,0,0,0,0,0);
        vecs[1]  = mk(1,0,1,0,     1,0,0,0,0,0,            0,0,0,0,0,0,0,0,0);
        vecs[2]  = mk(0,0,1,'h40,  0,0,0,0,'hDEADBEEF,0,   0,0,0,0,0,0,0,0,0);
        vecs[3]  = mk(0,0,1,'h40,  0,0,0,0,'hDEADBEEF,0,   1,0,0,0,0,'h40,0,0,0);
        vecs[4]  = mk(0,0,1,'h40,  0,0,0,0,'hDEADBEEF,0,   1,0,0,0,0,'h40,0,0,0);
        vecs[5]  = mk(0,0,1,'h40,  0,0,0,0,'hDEADBEEF,0,   1,0,0,0,0,'h40,0,0,0);
        vecs[6]  = mk(0,0,1,'h40,  0,0,0,0,'hDEADBEEF,1,   1,0,1,0,0,'h40,0,'hDEADBEEF,0);
        vecs[7]  = mk(0,0,0,0,     0,0,0,0,'hDEADBEEF,0,   0,0,0,0,0,0,0,0,0);
        vecs[8]  = mk(0,0,1,'h80,  0,1,'h100,5,0,1,        0,0,0,0,0,0,0,0,0);
        vecs[9]  = mk(0,0,1,'h80,  0,1,'h100,5,0,1,        0,1,0,1,0,'h100,5,0,0);
        vecs[10] = mk(0,0,1,'h80,  0,0,0,0,'h12345678,1,   0,0,0,0,0,0,0,0,0);
        vecs[11] = mk(0,0,1,'h80,  0,0,0,0,'h12345678,1,   1,0,1,0,0,'h80,0,'h12345678,0);
        vecs[12] = mk(0,0,0,0,     0,0,0,0,0,0,            0,0,0,0,0,0,0,0,0);
        vecs[13] = mk(0,0,0,0,     1,0,'h200,0,'hCAFEF00D,0, 0,0,0,0,0,0,0,0,0);
        vecs[14] = mk(0,0,0,0,     1,0,'h200,0,'hCAFEF00D,0, 1,0,0,0,0,'h200,0,0,0);
        vecs[15] = mk(1,0,0,0,     1,0,'h200,0,'hCAFEF00D,0, 1,0,0,0,0,'h200,0,0,0);
        vecs[16] = mk(0,0,0,0,     1,0,'h200,0,'hCAFEF00D,1, 0,0,0,0,0,0,0,0,0);
        vecs[17] = mk(0,0,0,0,     1,0,'h200,0,'hCAFEF00D,1, 1,0,0,1,0,'h200,0,0,'hCAFEF00D);
        vecs[18] = mk(0,0,0,0,     0,0,0,0,0,0,            0,0,0,0,0,0,0,0,0);

        clear_inputs();
        RST = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            RST = vecs[i].rst; halt = vecs[i].halt; iREN = vecs[i].iren;
            iaddr = vecs[i].iaddr; dREN = vecs[i].dren; dWEN = vecs[i].dwen;
            daddr = vecs[i].daddr; dstore = vecs[i].dstore;
            ramload = vecs[i].rload; ram_ready = vecs[i].rdy;
            @(negedge CLK);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
            tick();
        end

        // starvation guard: 4 data grants, then a forced fetch
        do_reset();
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400;
        ram_ready = 1'b1; ramload = 32'h77;
        seq = "";
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (dhit) seq = {seq, "D"};
            if (ihit) seq = {seq, "I"};
            tick();
        end
        n_tests++;
        if (seq != "DDDDIDDDDI") begin
            n_fail++;
            $display("FAIL streak_seq: got %s expected DDDDIDDDDI", seq);
        end

        // same traffic under halt: fetch never granted, data keeps flowing
        do_reset();
        halt = 1'b1; iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400;
        ram_ready = 1'b1;
        ni = 0; nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (ihit) ni++;
            if (dhit) nd++;
            tick();
        end
        chk("halt_ihits", 133'(ni), 133'(0));
        chk("halt_dhits", 133'(nd), 133'(10));

        // timeout on a read that never gets ram_ready
        do_reset();
        dREN = 1'b1; daddr = 32'h500; ram_ready = 1'b0;
        ren_cnt = 0; err_at = -1; dh_cnt = 0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            if (ramREN) ren_cnt++;
            if (dhit) dh_cnt++;
            if (err) begin
                err_at = ren_cnt;
                done = 1'b1;
            end
            tick();
        end
        chk("tmo_err_cycle", 133'(err_at), 133'(64));
        chk("tmo_no_dhit", 133'(dh_cnt), 133'(0));
        @(negedge CLK);
        chk("tmo_idle_after", {ramREN, err, dhit}, 133'(0));
        dREN = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
